// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_fifo
// Brief    : Synchronous FIFO with push, pop, clear and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_fifo #(
    parameter int               DEPTH = 2,
    parameter int               WIDTH = 65,
    parameter logic [WIDTH-1:0] FILL  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;
    logic             w_full;

    assign w_full    = (r_count == (c_AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Vacated slots read as FILL; a push to the same slot wins.
            if (w_do_pop) begin
                r_mem[r_rd_ptr] <= FILL;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : Fetches instruction words for the current PC into a decode FIFO.
//            Optional misaligned-PC trap enabled by IFETCH_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_en,
    input  logic            flush,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_fault,
    output logic            instr_valid,
    input  logic            instr_ready
);

    localparam int               c_EW   = 2*XLEN + 1;
    localparam int               c_CW   = $clog2(DEPTH) + 1;
    localparam logic [c_EW-1:0]  c_FILL = {1'b0, {XLEN{1'b0}}, XLEN'(c_NOP)};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_req_pc;
    logic              w_push;
    logic [c_EW-1:0]   w_push_data;
    logic              w_pop;
    logic [c_EW-1:0]   w_head;
    logic [c_CW-1:0]   w_count;
    logic              w_empty;
    logic              w_space;

    // Only IDLE can issue, and IDLE never has a response in flight.
    assign w_space = (w_count < c_CW'(DEPTH));
    assign w_pop   = !w_empty && instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (mem_req && mem_gnt) begin
                r_req_pc <= pc;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        pc_en       = 1'b0;
        w_push      = 1'b0;
        w_push_data = {1'b0, r_req_pc, mem_rdata};
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (!flush && w_space) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                        if (pc[1:0] != 2'b00) begin
                            w_push      = 1'b1;
                            w_push_data = {1'b1, pc, {XLEN{1'b0}}};
                            pc_en       = 1'b1;
                        end else
`endif
                        begin
                            mem_req = 1'b1;
                            if (mem_gnt) begin
                                pc_en       = 1'b1;
                                w_state_nxt = ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        w_state_nxt = ST_IDLE;
                        w_push      = !flush;
                    end else if (flush) begin
                        w_state_nxt = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (mem_rvalid) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign mem_addr    = pc;
    assign instr_fault = w_head[2*XLEN];
`else
    logic w_unused_fault;
    assign w_unused_fault = w_head[2*XLEN];
    assign mem_addr       = {pc[XLEN-1:2], 2'b00};
    assign instr_fault    = 1'b0;
`endif

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_EW),
        .FILL  (c_FILL)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_clear (flush),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign instr       = w_head[XLEN-1:0];
    assign instr_pc    = w_head[2*XLEN-1:XLEN];
    assign instr_valid = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Brief    : Self-checking bench for ifetch_unit against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;
    import ifetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_valid;
    logic        instr_ready;

    ifetch_unit #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_en       (pc_en),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          n_pcen = 0;
    entry_t      q[$];
    bit          m_busy = 0;
    bit          m_disc = 0;
    logic [31:0] m_req_pc = '0;
    logic [31:0] cur_pc = 32'h100;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, compare, then advance the model.
    task automatic step(input bit f, input bit g, input bit r, input bit allow,
                        input logic [31:0] rd);
        bit     rv, idle_ok, mis, e_req, e_fpush, e_pcen;
        entry_t e;
        @(negedge clk);
        pc          = cur_pc;
        flush       = f;
        mem_gnt     = g;
        instr_ready = r;
        rv          = m_busy && allow;
        mem_rvalid  = rv;
        mem_rdata   = rd;
        #1;
`ifdef IFETCH_MISALIGN_TRAP_EN
        mis = (cur_pc[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        idle_ok = !m_busy && (q.size() < DEPTH) && !f;
        e_req   = idle_ok && !mis;
        e_fpush = idle_ok && mis;
        e_pcen  = (e_req && g) || e_fpush;
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("pc_en", 32'(pc_en), 32'(e_pcen));
        if (e_req) chk("mem_addr", mem_addr, cur_pc & 32'hFFFF_FFFC);
        chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("instr", instr, q[0].instr);
            chk("instr_pc", instr_pc, q[0].pc);
            chk("instr_fault", 32'(instr_fault), 32'(q[0].fault));
        end
        if (pc_en) n_pcen++;
        @(posedge clk);
        if (f) begin
            q.delete();
            if (m_busy) begin
                if (rv) begin m_busy = 0; m_disc = 0; end
                else m_disc = 1;
            end
        end else begin
            if (q.size() > 0 && r) void'(q.pop_front());
            if (rv) begin
                if (!m_disc) begin
                    e.fault = 1'b0; e.pc = m_req_pc; e.instr = rd;
                    q.push_back(e);
                end
                m_busy = 0;
                m_disc = 0;
            end
            if (e_fpush) begin
                e.fault = 1'b1; e.pc = cur_pc; e.instr = 32'h0;
                q.push_back(e);
            end
        end
        if (e_req && g) begin
            m_busy   = 1;
            m_req_pc = cur_pc;
        end
        if (e_pcen) cur_pc = cur_pc + 32'd4;
    endtask

    initial begin
        int          n0;
        logic [31:0] tmp;
        rst = 1'b1; pc = 32'h100; flush = 0; mem_gnt = 0; mem_rvalid = 0;
        mem_rdata = 0; instr_ready = 0;
        @(negedge clk); #1;
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst pc_en", 32'(pc_en), 0);
        chk("rst instr_valid", 32'(instr_valid), 0);
        chk("rst instr", instr, 0);
        chk("rst instr_pc", instr_pc, 0);
        chk("rst instr_fault", 32'(instr_fault), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single fetch with one-cycle memory latency.
        cur_pc = 32'h100;
        n0 = n_pcen;
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'hDEADBEEF);
        #1;
        chk("t1 valid", 32'(instr_valid), 1);
        chk("t1 instr", instr, 32'hDEADBEEF);
        chk("t1 instr_pc", instr_pc, 32'h100);
        chk("t1 pc_en pulses", 32'(n_pcen - n0), 1);
        step(0, 0, 1, 0, 32'h0);

        // Decode stalled: only DEPTH fetches may be accepted.
        cur_pc = 32'h300;
        n0 = n_pcen;
        for (int i = 0; i < 12; i++) step(0, 1, 0, 1, 32'hA000_0000 + 32'(i));
        #1;
        chk("t2 pc_en pulses", 32'(n_pcen - n0), 2);
        chk("t2 mem_req", 32'(mem_req), 0);
        chk("t2 head instr", instr, 32'hA000_0001);
        chk("t2 head pc", instr_pc, 32'h300);
        step(0, 0, 1, 0, 32'h0);
        #1;
        chk("t2 second instr", instr, 32'hA000_0003);
        chk("t2 second pc", instr_pc, 32'h304);
        step(0, 0, 1, 0, 32'h0);

        // Flush while waiting; late response must be dropped.
        cur_pc = 32'h180;
        step(0, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        cur_pc = 32'h200;
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'h1111_1111);
        @(negedge clk);
        pc = cur_pc; mem_gnt = 0; mem_rvalid = 0; flush = 0; instr_ready = 0;
        #1;
        chk("t3 valid", 32'(instr_valid), 0);
        chk("t3 mem_req", 32'(mem_req), 1);
        chk("t3 mem_addr", mem_addr, 32'h200);

        // Flush coinciding with a response, one entry already buffered.
        cur_pc = 32'h400;
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'hC000_0001);
        step(0, 1, 0, 0, 32'h0);
        step(1, 0, 0, 1, 32'hC000_0002);
        cur_pc = 32'h500;
        #1;
        chk("t4 valid", 32'(instr_valid), 0);
        step(0, 0, 0, 0, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit f;
            f = ($urandom_range(0, 15) == 0);
            step(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0), $urandom);
            if (f) begin
                tmp = $urandom;
                cur_pc = tmp & 32'hFFFF_FFFC;
            end
        end

`ifdef IFETCH_MISALIGN_TRAP_EN
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        cur_pc = 32'h102;
        n0 = n_pcen;
        step(0, 1, 0, 0, 32'h0);
        #1;
        chk("mis pc_en pulses", 32'(n_pcen - n0), 1);
        chk("mis fault", 32'(instr_fault), 1);
        chk("mis instr_pc", instr_pc, 32'h102);
        chk("mis instr", instr, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
